// File: rtl/vseq_pkg.sv
// vseq_pkg: shared types and default parameters for the vector memory
// sequencer (vec_mem_sequencer and its sub-blocks).
//   state_t       sequencer FSM state encoding
//   VSEQ_N        lane / scalar word width in bits
//   VSEQ_V        lanes per vector register
//   VSEQ_L        lanes per memory beat
//   VSEQ_TIMEOUT  wait-cycle limit per beat (only used with VSEQ_TIMEOUT_EN)
package vseq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int VSEQ_N       = 32;
    localparam int VSEQ_V       = 20;
    localparam int VSEQ_L       = 4;
    localparam int VSEQ_TIMEOUT = 255;

endpackage

// File: rtl/vseq_mem_if.sv
// vseq_mem_if: narrow data-memory beat port, L lanes of N bits per beat.
//   master  sequencer side: drives request, write flag, address, lane
//           enables and write data; receives read data and ready
//   slave   memory side
// A beat completes on any cycle where mem_req_o && mem_ready_i.
interface vseq_mem_if
    import vseq_pkg::*;
#(
    parameter int N = VSEQ_N,
    parameter int L = VSEQ_L
);
    logic             mem_req_o;
    logic             mem_we_o;
    logic [N-1:0]     mem_addr_o;
    logic [L-1:0]     mem_be_o;
    logic [L*N-1:0]   mem_wdata_o;
    logic [L*N-1:0]   mem_rdata_i;
    logic             mem_ready_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_rdata_i, mem_ready_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_rdata_i, mem_ready_i
    );
endinterface

// File: rtl/vseq_load_buffer.sv
// vseq_load_buffer: V x N gather register for vector loads.
//   CLK       clock
//   RST       synchronous active-low clear (whole vector to 0)
//   wr_en     write one beat this cycle
//   scalar    1: write lane 0 only from wr_data lane 0
//   beat_idx  beat number; selects lanes [beat_idx*L +: L]
//   wr_data   L x N beat data
//   data      V x N gathered vector, held until overwritten
module vseq_load_buffer
    import vseq_pkg::*;
#(
    parameter int N  = VSEQ_N,
    parameter int V  = VSEQ_V,
    parameter int L  = VSEQ_L,
    parameter int BW = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             wr_en,
    input  logic             scalar,
    input  logic [BW-1:0]    beat_idx,
    input  logic [L*N-1:0]   wr_data,
    output logic [V*N-1:0]   data
);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            data <= '0;
        end else if (wr_en) begin
            if (scalar) begin
                data[N-1:0] <= wr_data[N-1:0];
            end else begin
                data[beat_idx*(L*N) +: L*N] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: MEM-stage sequencer that splits a V-lane vector access
// into V/L beats on the narrow data-memory port (one beat for scalars),
// stalls the pipeline while beats are outstanding and gathers load lanes.
//   CLK, RST                 clock, synchronous active-low reset
//   MemWE_i, WBSelect_i      store / load flags from EX/MEM (store wins)
//   OpSource_i               1 = vector, 0 = scalar
//   AluResult_S_i            word base address
//   RD2_S_i, RD2_V_i         scalar / vector store data
//   stall_o                  pipe-register enables are driven from ~stall_o
//   mem                      beat port (vseq_mem_if.master)
//   load_data_o, load_valid_o gathered load vector and its one-cycle valid
//   err_o                    one-cycle pulse when a beat times out
// Build option: define VSEQ_TIMEOUT_EN to abort a beat after TIMEOUT
// consecutive not-ready cycles; otherwise err_o is tied low.
//
// state  | meaning
// IDLE   | no access; a mem op raises stall and starts ACCESS
// ACCESS | beat b on the port, waiting for mem_ready_i
// DONE   | stall released for one cycle, load_valid_o/err_o reported
module vec_mem_sequencer
    import vseq_pkg::*;
#(
    parameter int N       = VSEQ_N,
    parameter int V       = VSEQ_V,
    parameter int L       = VSEQ_L,
    parameter int TIMEOUT = VSEQ_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MemWE_i,
    input  logic             WBSelect_i,
    input  logic             OpSource_i,
    input  logic [N-1:0]     AluResult_S_i,
    input  logic [N-1:0]     RD2_S_i,
    input  logic [V*N-1:0]   RD2_V_i,
    output logic             stall_o,
    vseq_mem_if.master       mem,
    output logic [V*N-1:0]   load_data_o,
    output logic             load_valid_o,
    output logic             err_o
);

    localparam int BEATS_V = V / L;
    localparam int BW      = (BEATS_V > 1) ? $clog2(BEATS_V) : 1;

    generate
        if (V % L != 0) begin : g_bad_lanes
            $error("vec_mem_sequencer: V must be a multiple of L");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("vec_mem_sequencer: TIMEOUT must be at least 1");
        end
    endgenerate

    state_t            state;
    logic [BW-1:0]     beat;
    logic [BW-1:0]     beat_nxt;
    logic              is_vec;
    logic              is_store;
    logic              mem_op;
    logic              beat_done;
    logic              last_beat;
    logic              timeout_hit;
    logic [L*N-1:0]    vec_wdata_nxt;

    assign mem_op        = MemWE_i | WBSelect_i;
    assign beat_done     = mem.mem_req_o & mem.mem_ready_i;
    assign last_beat     = !is_vec || (beat == BW'(BEATS_V - 1));
    assign beat_nxt      = beat + BW'(1);
    // Store data stays valid in the stalled EX/MEM register, so the next
    // beat's lanes can be read straight from it.
    assign vec_wdata_nxt = RD2_V_i[beat_nxt*(L*N) +: L*N];

    // Combinational so the pipe register freezes in the same cycle the op
    // appears; forced low while reset is asserted.
    assign stall_o = RST && (((state == IDLE) && mem_op) || (state == ACCESS));

`ifdef VSEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_cnt;

    assign timeout_hit = (state == ACCESS) && !mem.mem_ready_i
                         && (wait_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= timeout_hit;
            if ((state != ACCESS) || mem.mem_ready_i) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state           <= IDLE;
            beat            <= '0;
            is_vec          <= 1'b0;
            is_store        <= 1'b0;
            load_valid_o    <= 1'b0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_be_o    <= '0;
            mem.mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    load_valid_o <= 1'b0;
                    if (mem_op) begin
                        state          <= ACCESS;
                        beat           <= '0;
                        is_vec         <= OpSource_i;
                        is_store       <= MemWE_i;
                        mem.mem_req_o  <= 1'b1;
                        mem.mem_we_o   <= MemWE_i;
                        mem.mem_addr_o <= AluResult_S_i;
                        if (OpSource_i) begin
                            mem.mem_be_o    <= '1;
                            mem.mem_wdata_o <= RD2_V_i[L*N-1:0];
                        end else begin
                            mem.mem_be_o    <= L'(1);
                            mem.mem_wdata_o <= (L*N)'(RD2_S_i);
                        end
                    end
                end
                ACCESS: begin
                    if (beat_done) begin
                        if (last_beat) begin
                            state           <= DONE;
                            load_valid_o    <= !is_store;
                            mem.mem_req_o   <= 1'b0;
                            mem.mem_we_o    <= 1'b0;
                            mem.mem_addr_o  <= '0;
                            mem.mem_be_o    <= '0;
                            mem.mem_wdata_o <= '0;
                        end else begin
                            beat            <= beat_nxt;
                            mem.mem_addr_o  <= mem.mem_addr_o + N'(L);
                            mem.mem_wdata_o <= vec_wdata_nxt;
                        end
                    end else if (timeout_hit) begin
                        state           <= DONE;
                        load_valid_o    <= 1'b0;
                        mem.mem_req_o   <= 1'b0;
                        mem.mem_we_o    <= 1'b0;
                        mem.mem_addr_o  <= '0;
                        mem.mem_be_o    <= '0;
                        mem.mem_wdata_o <= '0;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    beat         <= '0;
                    load_valid_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    vseq_load_buffer #(
        .N  (N),
        .V  (V),
        .L  (L),
        .BW (BW)
    ) u_load_buffer (
        .CLK      (CLK),
        .RST      (RST),
        .wr_en    (beat_done && !is_store),
        .scalar   (!is_vec),
        .beat_idx (beat),
        .wr_data  (mem.mem_rdata_i),
        .data     (load_data_o)
    );

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer. The memory model returns, in each
// lane j of a beat, the value (beat address + j).
module tb_vec_mem_sequencer;
    localparam int N = 32;
    localparam int V = 20;
    localparam int L = 4;
`ifdef VSEQ_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 255;
`endif

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           MemWE_i = 1'b0;
    logic           WBSelect_i = 1'b0;
    logic           OpSource_i = 1'b0;
    logic [N-1:0]   AluResult_S_i = '0;
    logic [N-1:0]   RD2_S_i = '0;
    logic [V*N-1:0] RD2_V_i = '0;
    logic           stall_o;
    logic [V*N-1:0] load_data_o;
    logic           load_valid_o;
    logic           err_o;

    vseq_mem_if #(.N(N), .L(L)) mem_bus ();

    vec_mem_sequencer #(.N(N), .V(V), .L(L), .TIMEOUT(TIMEOUT)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .MemWE_i       (MemWE_i),
        .WBSelect_i    (WBSelect_i),
        .OpSource_i    (OpSource_i),
        .AluResult_S_i (AluResult_S_i),
        .RD2_S_i       (RD2_S_i),
        .RD2_V_i       (RD2_V_i),
        .stall_o       (stall_o),
        .mem           (mem_bus),
        .load_data_o   (load_data_o),
        .load_valid_o  (load_valid_o),
        .err_o         (err_o)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        mem_bus.mem_rdata_i = '0;
        for (int j = 0; j < L; j++)
            mem_bus.mem_rdata_i[j*N +: N] = mem_bus.mem_addr_o + N'(j);
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // per-run observations filled by run_access
    int             n_stall, n_beats, n_valid, n_err, n_rec, first_req;
    bit             done_seen, done_valid, done_err;
    logic [V*N-1:0] cap_data;
    logic [N-1:0]   rec_addr  [32];
    logic [L*N-1:0] rec_wdata [32];
    logic [L-1:0]   rec_be    [32];
    logic           rec_we    [32];
    int             rec_beat  [32];
    int             hold_beat = -1;
    int             hold_n    = 0;
    bit             stuck_low = 1'b0;

    task automatic issue(input logic we, input logic wb, input logic vec,
                         input logic [N-1:0] addr, input logic [N-1:0] sdata);
        @(posedge CLK); #1;
        MemWE_i = we; WBSelect_i = wb; OpSource_i = vec;
        AluResult_S_i = addr; RD2_S_i = sdata;
        mem_bus.mem_ready_i = 1'b1;
    endtask

    task automatic drop_op();
        @(posedge CLK); #1;
        MemWE_i = 1'b0; WBSelect_i = 1'b0;
    endtask

    // Samples cycle by cycle from the op's first MEM cycle; returns at the
    // negedge of the first non-stalled cycle after the stall (DONE).
    task automatic run_access(input int max_cyc);
        int waited;
        waited = 0;
        n_stall = 0; n_beats = 0; n_valid = 0; n_err = 0; n_rec = 0; first_req = 0;
        done_seen = 1'b0; done_valid = 1'b0; done_err = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge CLK);
            if (err_o) n_err++;
            if (load_valid_o) begin
                n_valid++;
                cap_data = load_data_o;
            end
            if (mem_bus.mem_req_o) begin
                if (first_req == 0) first_req = c;
                if (n_rec < 32) begin
                    rec_addr[n_rec]  = mem_bus.mem_addr_o;
                    rec_wdata[n_rec] = mem_bus.mem_wdata_o;
                    rec_be[n_rec]    = mem_bus.mem_be_o;
                    rec_we[n_rec]    = mem_bus.mem_we_o;
                    rec_beat[n_rec]  = n_beats;
                    n_rec++;
                end
                if (mem_bus.mem_ready_i) n_beats++;
            end
            if (stall_o) begin
                n_stall++;
            end else if (n_stall > 0) begin
                done_seen  = 1'b1;
                done_valid = load_valid_o;
                done_err   = err_o;
                break;
            end
            @(posedge CLK); #1;
            if (mem_bus.mem_req_o && (stuck_low || (n_beats == hold_beat && waited < hold_n))) begin
                mem_bus.mem_ready_i = 1'b0;
                waited++;
            end else begin
                mem_bus.mem_ready_i = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        mem_bus.mem_ready_i = 1'b1;
        repeat (2) @(posedge CLK);
        #1 MemWE_i = 1'b1;
        @(negedge CLK);
        chk_cnt++;
        if (stall_o !== 1'b0) $display("FAIL reset_stall_forced: got %0b expected 0", stall_o);
        else pass_cnt++;
        chk_cnt++;
        if ({mem_bus.mem_req_o, mem_bus.mem_we_o, load_valid_o, err_o} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {mem_bus.mem_req_o, mem_bus.mem_we_o, load_valid_o, err_o});
        else pass_cnt++;
        chk_cnt++;
        if ({mem_bus.mem_addr_o, mem_bus.mem_be_o, mem_bus.mem_wdata_o} !== '0)
            $display("FAIL reset_bus: got addr %0h be %0h wdata %0h expected 0",
                     mem_bus.mem_addr_o, mem_bus.mem_be_o, mem_bus.mem_wdata_o);
        else pass_cnt++;
        chk_cnt++;
        if (load_data_o !== '0) $display("FAIL reset_load_data: got %0h expected 0", load_data_o);
        else pass_cnt++;
        @(posedge CLK); #1;
        MemWE_i = 1'b0;
        RST = 1'b1;
    endtask

    task automatic test_vec_load();
        int bad;
        issue(1'b0, 1'b1, 1'b1, 32'h100, '0);
        run_access(30);
        chk_cnt++;
        if (!done_seen || n_stall != 6) $display("FAIL vload_stall: got %0d cycles (done %0b) expected 6", n_stall, done_seen);
        else pass_cnt++;
        bad = (n_rec == 5) ? -1 : 99;
        for (int i = 0; i < n_rec && bad < 0; i++)
            if (rec_addr[i] !== N'(32'h100 + 4*i) || rec_be[i] !== 4'hF || rec_we[i] !== 1'b0) bad = i;
        chk_cnt++;
        if (bad >= 0) $display("FAIL vload_beats: %0d beats, bad beat %0d got addr %0h expected %0h", n_rec, bad,
                               (bad < n_rec) ? rec_addr[bad] : '0, 32'h100 + 4*bad);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid != 1 || !done_valid) $display("FAIL vload_valid: got %0d pulses expected 1 in DONE", n_valid);
        else pass_cnt++;
        bad = -1;
        for (int k = 0; k < V; k++)
            if (bad < 0 && cap_data[k*N +: N] !== N'(32'h100 + k)) bad = k;
        chk_cnt++;
        if (bad >= 0) $display("FAIL vload_data: lane %0d got %0h expected %0h", bad, cap_data[bad*N +: N], 32'h100 + bad);
        else pass_cnt++;
        drop_op();
        @(negedge CLK);
        chk_cnt++;
        if (load_valid_o !== 1'b0 || stall_o !== 1'b0 || load_data_o[19*N +: N] !== 32'h113)
            $display("FAIL vload_after: got valid %0b stall %0b lane19 %0h expected 0 0 113",
                     load_valid_o, stall_o, load_data_o[19*N +: N]);
        else pass_cnt++;
    endtask

    task automatic test_vec_store_wait();
        int n2, bad;
        for (int k = 0; k < V; k++) RD2_V_i[k*N +: N] = N'(k);
        hold_beat = 2; hold_n = 2;
        issue(1'b1, 1'b0, 1'b1, 32'h40, '0);
        run_access(30);
        hold_beat = -1;
        chk_cnt++;
        if (!done_seen || n_stall != 8) $display("FAIL vstore_stall: got %0d cycles expected 8", n_stall);
        else pass_cnt++;
        chk_cnt++;
        if (n_beats != 5) $display("FAIL vstore_beats: got %0d expected 5", n_beats);
        else pass_cnt++;
        n2 = 0; bad = 0;
        for (int i = 0; i < n_rec; i++) begin
            if (rec_we[i] !== 1'b1) bad++;
            if (rec_beat[i] == 2) begin
                n2++;
                if (rec_addr[i] !== 32'h48 || rec_wdata[i] !== 128'h0000000b_0000000a_00000009_00000008) bad++;
            end
        end
        chk_cnt++;
        if (n2 != 3 || bad != 0) $display("FAIL vstore_beat2: got %0d cycles %0d bad expected 3 cycles 0 bad", n2, bad);
        else pass_cnt++;
        chk_cnt++;
        if (n_rec < 1 || rec_addr[n_rec-1] !== 32'h50 || rec_wdata[n_rec-1] !== 128'h00000013_00000012_00000011_00000010)
            $display("FAIL vstore_last: got addr %0h wdata %0h expected 50 00000013000000120000001100000010",
                     rec_addr[n_rec-1], rec_wdata[n_rec-1]);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid != 0 || n_err != 0) $display("FAIL vstore_valid: got valid %0d err %0d expected 0 0", n_valid, n_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b1, 1'b0, 32'h7, '0);
        run_access(10);
        chk_cnt++;
        if (n_stall != 2 || n_rec != 1 || rec_be[0] !== 4'b0001 || rec_addr[0] !== 32'h7 || rec_we[0] !== 1'b0)
            $display("FAIL sload_beat: got stall %0d beats %0d be %b addr %0h we %0b expected 2 1 0001 7 0",
                     n_stall, n_rec, rec_be[0], rec_addr[0], rec_we[0]);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid != 1 || cap_data[N-1:0] !== 32'h7 || cap_data[2*N-1:N] !== 32'h101)
            $display("FAIL sload_data: got valid %0d lane0 %0h lane1 %0h expected 1 7 101",
                     n_valid, cap_data[N-1:0], cap_data[2*N-1:N]);
        else pass_cnt++;
        // next op enters MEM as DONE ends: IDLE cycle stalls, beat follows
        issue(1'b1, 1'b0, 1'b0, 32'h8, 32'hAB);
        run_access(10);
        chk_cnt++;
        if (first_req != 2 || n_stall != 2) $display("FAIL sstore_timing: got first beat cycle %0d stall %0d expected 2 2", first_req, n_stall);
        else pass_cnt++;
        chk_cnt++;
        if (n_rec != 1 || rec_be[0] !== 4'b0001 || rec_we[0] !== 1'b1 || rec_addr[0] !== 32'h8 || rec_wdata[0] !== 128'hAB)
            $display("FAIL sstore_beat: got be %b we %0b addr %0h wdata %0h expected 0001 1 8 ab",
                     rec_be[0], rec_we[0], rec_addr[0], rec_wdata[0]);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid != 0) $display("FAIL sstore_valid: got %0d expected 0", n_valid);
        else pass_cnt++;
        drop_op();
    endtask

    task automatic test_both_flags();
        int bad;
        issue(1'b1, 1'b1, 1'b1, 32'h200, '0);
        run_access(20);
        bad = 0;
        for (int i = 0; i < n_rec; i++) if (rec_we[i] !== 1'b1) bad++;
        chk_cnt++;
        if (n_rec != 5 || bad != 0) $display("FAIL both_we: got %0d beats %0d non-write expected 5 0", n_rec, bad);
        else pass_cnt++;
        chk_cnt++;
        if (n_valid != 0 || load_data_o[N-1:0] !== 32'h7)
            $display("FAIL both_valid: got valid %0d lane0 %0h expected 0 7", n_valid, load_data_o[N-1:0]);
        else pass_cnt++;
        drop_op();
    endtask

    task automatic test_non_mem();
        int bad;
        issue(1'b0, 1'b0, 1'b1, 32'h300, '0);
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (stall_o !== 1'b0 || mem_bus.mem_req_o !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL non_mem: got %0d stalled cycles expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int bad;
        issue(1'b0, 1'b1, 1'b1, 32'h100, '0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk_cnt++;
        if (mem_bus.mem_req_o !== 1'b1 || mem_bus.mem_addr_o !== 32'h10C)
            $display("FAIL rst_beat3: got req %0b addr %0h expected 1 10c", mem_bus.mem_req_o, mem_bus.mem_addr_o);
        else pass_cnt++;
        RST = 1'b0; MemWE_i = 1'b0; WBSelect_i = 1'b0;
        #1;
        chk_cnt++;
        if (stall_o !== 1'b0) $display("FAIL rst_stall_forced: got %0b expected 0", stall_o);
        else pass_cnt++;
        @(negedge CLK);
        chk_cnt++;
        if ({stall_o, mem_bus.mem_req_o, mem_bus.mem_we_o, load_valid_o, err_o} !== 5'b0 ||
            {mem_bus.mem_addr_o, mem_bus.mem_be_o, mem_bus.mem_wdata_o} !== '0 || load_data_o !== '0)
            $display("FAIL rst_outputs: got flags %b addr %0h lane0 %0h expected 0",
                     {stall_o, mem_bus.mem_req_o, mem_bus.mem_we_o, load_valid_o, err_o},
                     mem_bus.mem_addr_o, load_data_o[N-1:0]);
        else pass_cnt++;
        @(posedge CLK); #1;
        RST = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge CLK);
            if (load_valid_o !== 1'b0 || mem_bus.mem_req_o !== 1'b0) bad++;
        end
        chk_cnt++;
        if (bad != 0) $display("FAIL rst_no_valid: got %0d active cycles expected 0", bad);
        else pass_cnt++;
    endtask

`ifdef VSEQ_TIMEOUT_EN
    task automatic test_timeout();
        stuck_low = 1'b1;
        issue(1'b0, 1'b1, 1'b1, 32'h100, '0);
        run_access(20);
        stuck_low = 1'b0;
        chk_cnt++;
        if (!done_seen || n_stall != 5 || n_rec != 4)
            $display("FAIL tmo_stall: got stall %0d waits %0d expected 5 4", n_stall, n_rec);
        else pass_cnt++;
        chk_cnt++;
        if (n_err != 1 || !done_err || n_valid != 0)
            $display("FAIL tmo_err: got err %0d in_done %0b valid %0d expected 1 1 0", n_err, done_err, n_valid);
        else pass_cnt++;
        drop_op();
        @(negedge CLK);
        chk_cnt++;
        if (err_o !== 1'b0) $display("FAIL tmo_pulse: got %0b expected 0", err_o);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_vec_load();
        test_vec_store_wait();
        test_back_to_back();
        test_both_flags();
        test_non_mem();
        test_mid_reset();
`ifdef VSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
